gpio_irq: RTL and testbench
===========================

Name: gpio_irq

Overview:
- Parametrised successor to the fixed 16-pin GPIO slave on the RIB bus.
- Pin count is configurable, and direction and output are per-bit registers instead of 2-bit control fields.
- Inputs pass through a synchroniser and feed per-pin level/edge interrupt logic with a write-1-to-clear pending register.
- `irq_o` drives one bit of the core's `int_i` vector. The tri-state pads stay in the SoC top, built from `io_out_o` and `io_oe_o`.

Parameters:
- GPIO_NUM, 16, number of pins; legal range 1..32.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.
- DEBOUNCE_CYCLES, 8, stable-cycle count for the debounce filter; legal range 1..255; used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- we_i  in  1  bus write strobe
- addr_i  in  32  bus address; only addr_i[7:0] is decoded
- data_i  in  32  bus write data
- data_o  out  32  bus read data, combinational
- io_pin_i  in  GPIO_NUM  raw pad inputs, asynchronous
- io_out_o  out  GPIO_NUM  pad output values (= OUT register)
- io_oe_o  out  GPIO_NUM  pad output enables (= DIR register)
- irq_o  out  1  interrupt request, registered, level

Behaviour:
- Reset (async, rst=1):
  - All registers, synchroniser flops and edge-history flops clear to 0.
  - io_out_o=0, io_oe_o=0 (all pins inputs), irq_o=0.
- Register map (byte offsets):
  - 0x00 DIR rw: 1 = output.
  - 0x04 OUT rw.
  - 0x08 IN ro: filtered input value.
  - 0x0C IRQ_EN rw.
  - 0x10 IRQ_TYPE rw: 0 = level, 1 = edge.
  - 0x14 IRQ_POL rw: 0 = low/falling, 1 = high/rising.
  - 0x18 IRQ_PEND: edge bits are W1C; level bits read-only.
  - 0x1C OUT_TGL wo: OUT ^= data_i; reads 0.
- Bits at or above GPIO_NUM read 0 and ignore writes. Unmapped offsets read 0 and ignore writes.
- Writes take effect on the rising clk edge when we_i=1. data_o is a combinational decode of addr_i, valid in the same cycle. Register side effects depend on we_i only; there is no request signal.
- Input path:
  - io_pin_i → SYNC_STAGES flop chain → filter → in_q.
  - Without debounce, the filter is a wire, so a pin change is visible in IN after SYNC_STAGES rising edges.
  - in_d is in_q delayed by one cycle. rise = in_q & ~in_d; fall = ~in_q & in_d.
- Pending, edge pins (TYPE=1):
  - PEND[i] is set on the clock after rise (POL=1) or fall (POL=0), only if IRQ_EN[i]=1.
  - A W1C write clears the bit. If a new edge and the W1C clear land in the same cycle, set wins.
  - Clearing IRQ_EN does not clear PEND.
- Pending, level pins (TYPE=0):
  - PEND[i] = IRQ_EN[i] & (in_q[i]==POL[i]), combinational.
  - W1C has no effect on level bits.
- Changing TYPE or POL never produces an edge. Edges come only from the input path. When a pin is switched to edge mode, its stored pending bit starts from its previous edge-mode value, which is 0 after reset.
- irq_o is registered: it equals |(PEND & IRQ_EN) from the previous cycle.
  - Edge pin: the interrupt asserts SYNC_STAGES+2 edges after the pin change.
  - Level pin: the interrupt asserts SYNC_STAGES+1 edges after the pin change.
- Output pins still feed the input path, so IN reflects the driven pad. This allows self-triggered interrupts.
- Reset during activity: everything returns immediately to reset values. No pending state survives reset.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- When defined:
  - Each pin gets an 8-bit stable counter between the synchroniser output and in_q.
  - in_q[i] updates only after the synchronised value has differed from in_q[i] for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the in_q value resets that pin's counter to 0.
  - Edges and level matches use the filtered in_q.
  - Added latency is DEBOUNCE_CYCLES cycles.
- When undefined: no counters, the filter is a wire, and DEBOUNCE_CYCLES is ignored.

Test Plan:
- Reset, then read all offsets → all read 0x00000000. io_oe_o=0, io_out_o=0, irq_o=0.
- GPIO_NUM=16:
  - Write DIR=0xFFFFFFFF, OUT=0x0000A5A5 → DIR reads 0x0000FFFF; io_oe_o=16'hFFFF; io_out_o=16'hA5A5.
  - Then OUT_TGL=0x0000FFFF → OUT reads 0x00005A5A.
- Edge interrupt:
  - Setup: IRQ_EN=0x1, TYPE=0x1, POL=0x1, SYNC_STAGES=2.
  - Drive io_pin_i[0] 0→1 before edge 0 → IN[0]=1 after edge 2; PEND=0x1 after edge 3; irq_o=1 after edge 4.
  - Write PEND=0x1 → irq_o drops one cycle later.
- Simultaneous set and clear: a W1C of PEND[3] in the same cycle a falling edge on pin 3 sets it (TYPE=1, POL=0) → PEND[3] stays 1.
- Level interrupt:
  - Setup: pin 5 with IRQ_EN=1, TYPE=0, POL=0; pin held low → PEND[5]=1 and irq_o=1.
  - Write PEND=0x20 → PEND[5] stays 1.
  - Drive pin high → irq_o drops SYNC_STAGES+1 edges later.
- Debounce (macro defined, DEBOUNCE_CYCLES=8):
  - A 5-cycle glitch on pin 2 → IN[2] never changes and no PEND.
  - A 20-cycle high pulse → IN[2] goes high SYNC_STAGES+8 cycles after the rise.
  - Asserting rst mid-count → counter, IN and PEND all read 0.

Source files
------------

// File: rtl/gpio_irq.sv
// gpio_irq: parametrised GPIO block with per-pin level/edge interrupts.
// Inputs pass through a SYNC_STAGES flop chain and an optional debounce
// filter before feeding the IN register and the interrupt logic.
// Optional feature macro: GPIO_DEBOUNCE_EN (per-pin stable-count filter).
module gpio_irq #(
    parameter int GPIO_NUM        = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    input  logic [GPIO_NUM-1:0] io_pin_i,
    output logic [GPIO_NUM-1:0] io_out_o,
    output logic [GPIO_NUM-1:0] io_oe_o,
    output logic                irq_o
);

    localparam logic [7:0] ADDR_DIR  = 8'h00;
    localparam logic [7:0] ADDR_OUT  = 8'h04;
    localparam logic [7:0] ADDR_IN   = 8'h08;
    localparam logic [7:0] ADDR_EN   = 8'h0C;
    localparam logic [7:0] ADDR_TYPE = 8'h10;
    localparam logic [7:0] ADDR_POL  = 8'h14;
    localparam logic [7:0] ADDR_PEND = 8'h18;
    localparam logic [7:0] ADDR_TGL  = 8'h1C;

    logic [7:0]          addr8;
    logic [GPIO_NUM-1:0] wdata;
    logic [GPIO_NUM-1:0] dir_q, out_q, en_q, type_q, pol_q;
    logic [GPIO_NUM-1:0] pend_edge_q, pend_edge_d;
    logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
    logic [GPIO_NUM-1:0] in_q, in_dly_q;
    logic [GPIO_NUM-1:0] rise, fall, edge_set, w1c_clr, pend, rd_pins;
    logic                irq_q, irq_d;
    logic                unused_addr;
    logic                wr_dir, wr_out, wr_en, wr_type, wr_pol, wr_pend, wr_tgl;

    assign addr8       = addr_i[7:0];
    assign unused_addr = ^addr_i[31:8];
    assign wdata       = data_i[GPIO_NUM-1:0];

    // Upper data bits are ignored when fewer than 32 pins exist.
    generate
        if (GPIO_NUM < 32) begin : g_unused_data
            logic unused_data;
            assign unused_data = ^data_i[31:GPIO_NUM];
        end
    endgenerate

    assign wr_dir  = we_i && (addr8 == ADDR_DIR);
    assign wr_out  = we_i && (addr8 == ADDR_OUT);
    assign wr_en   = we_i && (addr8 == ADDR_EN);
    assign wr_type = we_i && (addr8 == ADDR_TYPE);
    assign wr_pol  = we_i && (addr8 == ADDR_POL);
    assign wr_pend = we_i && (addr8 == ADDR_PEND);
    assign wr_tgl  = we_i && (addr8 == ADDR_TGL);

    // Input synchroniser chain; the last stage is the synchronised pin value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= io_pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    genvar gi;
    generate
        for (gi = 0; gi < GPIO_NUM; gi++) begin : g_deb
            logic [7:0] cnt_q, cnt_d;
            logic       flt_q, flt_d;

            // Count consecutive cycles of disagreement; accept the new value
            // once it has held for DEBOUNCE_CYCLES cycles.
            always_comb begin
                cnt_d = '0;
                flt_d = flt_q;
                if (sync_q[SYNC_STAGES-1][gi] != flt_q) begin
                    if (cnt_q == DEB_LAST) begin
                        flt_d = sync_q[SYNC_STAGES-1][gi];
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            // Debounce counter and filtered value registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    flt_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    flt_q <= flt_d;
                end
            end

            assign in_q[gi] = flt_q;
        end
    endgenerate
`else
    // Without debounce the filtered value is the synchroniser output itself.
    assign in_q = sync_q[SYNC_STAGES-1];
`endif

    assign rise     = in_q & ~in_dly_q;
    assign fall     = ~in_q & in_dly_q;
    assign edge_set = type_q & en_q & ((pol_q & rise) | (~pol_q & fall));
    assign w1c_clr  = wr_pend ? (wdata & type_q) : '0;

    // Edge pending bits: set wins over a simultaneous W1C clear. Level pins
    // leave their stored edge bit untouched so it survives a mode switch.
    assign pend_edge_d = (pend_edge_q & ~w1c_clr) | edge_set;

    assign pend  = (type_q & pend_edge_q) | (~type_q & en_q & ~(in_q ^ pol_q));
    assign irq_d = |(pend & en_q);

    // Control registers, edge history, pending state and interrupt flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q       <= '0;
            out_q       <= '0;
            en_q        <= '0;
            type_q      <= '0;
            pol_q       <= '0;
            pend_edge_q <= '0;
            in_dly_q    <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_dir)  dir_q  <= wdata;
            if (wr_out)       out_q <= wdata;
            else if (wr_tgl)  out_q <= out_q ^ wdata;
            if (wr_en)   en_q   <= wdata;
            if (wr_type) type_q <= wdata;
            if (wr_pol)  pol_q  <= wdata;
            pend_edge_q <= pend_edge_d;
            in_dly_q    <= in_q;
            irq_q       <= irq_d;
        end
    end

    // Combinational read decode; unmapped offsets and OUT_TGL read zero.
    always_comb begin
        rd_pins = '0;
        case (addr8)
            ADDR_DIR:  rd_pins = dir_q;
            ADDR_OUT:  rd_pins = out_q;
            ADDR_IN:   rd_pins = in_q;
            ADDR_EN:   rd_pins = en_q;
            ADDR_TYPE: rd_pins = type_q;
            ADDR_POL:  rd_pins = pol_q;
            ADDR_PEND: rd_pins = pend;
            default:   rd_pins = '0;
        endcase
        data_o = '0;
        data_o[GPIO_NUM-1:0] = rd_pins;
    end

    assign io_out_o = out_q;
    assign io_oe_o  = dir_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq (GPIO_NUM=16, SYNC_STAGES=2). Expected values
// are queued as stimulus is applied and compared when drained between edges.
// Debounce cases are included when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_irq;

    localparam int NPIN = 16;
    localparam int SY   = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int FLT  = 8;
`else
    localparam int FLT  = 0;
`endif
    localparam int LAT  = SY + FLT;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;
    localparam int K_OE  = 2;
    localparam int K_OUT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            we_i = 1'b0;
    logic [31:0]     addr_i = '0;
    logic [31:0]     data_i = '0;
    logic [31:0]     data_o;
    logic [NPIN-1:0] io_pin_i = '0;
    logic [NPIN-1:0] io_out_o;
    logic [NPIN-1:0] io_oe_o;
    logic            irq_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [7:0]  addr;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    gpio_irq #(.GPIO_NUM(NPIN), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .io_pin_i(io_pin_i), .io_out_o(io_out_o),
        .io_oe_o(io_oe_o), .irq_o(irq_o)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [7:0] a, input logic [31:0] e);
        sb_t t;
        t.tag = tag; t.kind = kind; t.addr = a; t.exp = e;
        sb_q.push_back(t);
    endtask

    task automatic drain();
        sb_t t;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            case (t.kind)
                K_RD:    begin addr_i = {24'h0, t.addr}; #1; obs = data_o; end
                K_IRQ:   obs = {31'h0, irq_o};
                K_OE:    obs = 32'(io_oe_o);
                default: obs = 32'(io_out_o);
            endcase
            check(t.tag, obs, t.exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1; addr_i = {24'h0, a}; data_i = d;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        rst = 1'b0;
        for (int a = 0; a <= 8'h20; a += 4) push($sformatf("rst_rd_%02h", a), K_RD, 8'(a), 32'h0);
        push("rst_oe", K_OE, 8'h0, 32'h0);
        push("rst_out", K_OUT, 8'h0, 32'h0);
        push("rst_irq", K_IRQ, 8'h0, 32'h0);
        drain();

        // DIR/OUT/OUT_TGL and unused bits
        wr(8'h00, 32'hFFFF_FFFF);
        wr(8'h04, 32'h0000_A5A5);
        push("dir_rd", K_RD, 8'h00, 32'h0000_FFFF);
        push("out_rd", K_RD, 8'h04, 32'h0000_A5A5);
        push("oe_pins", K_OE, 8'h0, 32'h0000_FFFF);
        push("out_pins", K_OUT, 8'h0, 32'h0000_A5A5);
        drain();
        wr(8'h1C, 32'h0000_FFFF);
        push("tgl_out", K_RD, 8'h04, 32'h0000_5A5A);
        push("tgl_rd0", K_RD, 8'h1C, 32'h0);
        drain();
        wr(8'h20, 32'hFFFF_FFFF);
        push("unmapped_rd", K_RD, 8'h20, 32'h0);
        push("unmapped_dir", K_RD, 8'h00, 32'h0000_FFFF);
        drain();
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);

        // Edge interrupt on pin 0
        wr(8'h0C, 32'h1);
        wr(8'h10, 32'h1);
        wr(8'h14, 32'h1);
        push("type_rd", K_RD, 8'h10, 32'h1);
        push("pol_rd", K_RD, 8'h14, 32'h1);
        drain();
        io_pin_i[0] = 1'b1;
        step(LAT);
        push("edge_in", K_RD, 8'h08, 32'h1);
        push("edge_pend0", K_RD, 8'h18, 32'h0);
        push("edge_irq0", K_IRQ, 8'h0, 32'h0);
        drain();
        step(1);
        push("edge_pend1", K_RD, 8'h18, 32'h1);
        push("edge_irq1", K_IRQ, 8'h0, 32'h0);
        drain();
        step(1);
        push("edge_irq2", K_IRQ, 8'h0, 32'h1);
        drain();
        wr(8'h18, 32'h1);
        push("w1c_irq_hold", K_IRQ, 8'h0, 32'h1);
        push("w1c_pend", K_RD, 8'h18, 32'h0);
        drain();
        step(1);
        push("w1c_irq_drop", K_IRQ, 8'h0, 32'h0);
        drain();

        // Simultaneous set and clear on pin 3 (falling edge)
        wr(8'h0C, 32'h9);
        wr(8'h10, 32'h9);
        wr(8'h14, 32'h1);
        io_pin_i[3] = 1'b1;
        step(LAT + 2);
        push("sc_pre_pend", K_RD, 8'h18, 32'h0);
        drain();
        io_pin_i[3] = 1'b0;
        repeat (LAT) @(posedge clk);
        wr(8'h18, 32'h8);
        push("sc_set_wins", K_RD, 8'h18, 32'h8);
        drain();
        step(1);
        push("sc_irq", K_IRQ, 8'h0, 32'h1);
        drain();
        wr(8'h0C, 32'h0);
        push("en_clr_keeps_pend", K_RD, 8'h18, 32'h8);
        drain();
        wr(8'h18, 32'h8);
        push("sc_w1c", K_RD, 8'h18, 32'h0);
        drain();

        // Level interrupt on pin 5 (active low)
        wr(8'h0C, 32'h20);
        wr(8'h10, 32'h0);
        wr(8'h14, 32'h0);
        push("lvl_pend", K_RD, 8'h18, 32'h20);
        drain();
        step(1);
        push("lvl_irq", K_IRQ, 8'h0, 32'h1);
        drain();
        wr(8'h18, 32'h20);
        push("lvl_w1c_noeff", K_RD, 8'h18, 32'h20);
        drain();
        io_pin_i[5] = 1'b1;
        step(LAT);
        push("lvl_irq_hold", K_IRQ, 8'h0, 32'h1);
        push("lvl_pend_off", K_RD, 8'h18, 32'h0);
        drain();
        step(1);
        push("lvl_irq_drop", K_IRQ, 8'h0, 32'h0);
        drain();

        // Reset during activity
        wr(8'h00, 32'h00FF);
        wr(8'h14, 32'h20);
        step(1);
        push("pre_rst_irq", K_IRQ, 8'h0, 32'h1);
        drain();
        #3 rst = 1'b1;
        #1;
        push("mid_rst_irq", K_IRQ, 8'h0, 32'h0);
        push("mid_rst_oe", K_OE, 8'h0, 32'h0);
        push("mid_rst_in", K_RD, 8'h08, 32'h0);
        push("mid_rst_pend", K_RD, 8'h18, 32'h0);
        push("mid_rst_pol", K_RD, 8'h14, 32'h0);
        drain();
        io_pin_i = '0;
        step(2);
        rst = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
        // Debounce: short glitch is rejected, long pulse accepted
        step(LAT + 2);
        wr(8'h0C, 32'h4);
        wr(8'h10, 32'h4);
        wr(8'h14, 32'h4);
        io_pin_i[2] = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        io_pin_i[2] = 1'b0;
        step(30);
        push("glitch_in", K_RD, 8'h08, 32'h0);
        push("glitch_pend", K_RD, 8'h18, 32'h0);
        drain();
        io_pin_i[2] = 1'b1;
        step(LAT - 1);
        push("deb_in_early", K_RD, 8'h08, 32'h0);
        drain();
        step(1);
        push("deb_in_late", K_RD, 8'h08, 32'h4);
        drain();
        step(1);
        push("deb_pend", K_RD, 8'h18, 32'h4);
        drain();
        step(20 - LAT - 2);
        io_pin_i[2] = 1'b0;
        step(5);
        #3 rst = 1'b1;
        #1;
        push("deb_rst_in", K_RD, 8'h08, 32'h0);
        push("deb_rst_pend", K_RD, 8'h18, 32'h0);
        drain();
        step(2);
        rst = 1'b0;
        step(12);
        push("deb_post_rst_in", K_RD, 8'h08, 32'h0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
